// File: rtl/apb_interrupt_controller_if.sv
// ----------------------------------------------------------------------------
// apb_interrupt_controller_if
//   APB bus bundle shared by the interrupt controller (slave side) and its
//   bus master. The sole clock and the asynchronous active-low reset travel
//   with the bus because every register and source sits in that domain.
// Signals
//   pclk, preset_n   clock and async active-low reset (interface ports)
//   psel, penable    transfer select / access phase            (master -> slave)
//   pwrite           1 = write, 0 = read                        (master -> slave)
//   paddr, pwdata    byte address / write data                  (master -> slave)
//   pready           one-cycle completion strobe                (slave -> master)
//   prdata, pslverr  read data / error, valid with pready       (slave -> master)
// ----------------------------------------------------------------------------
interface apb_interrupt_controller_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input logic pclk,
    input logic preset_n
);

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  pclk, preset_n, pready, prdata, pslverr,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        input  pclk, preset_n, psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_interrupt_controller.sv
// ----------------------------------------------------------------------------
// apb_interrupt_controller
//   Latches up to NUM_IRQS interrupt sources (per-source edge/level mode,
//   polarity and enable), exposes them through a small APB register file with
//   write-1-to-clear status, and drives one registered irq pin. After any
//   status clear the irq pin can be held off for HOLDOFF cycles to coalesce
//   bursts of interrupts.
// Ports
//   apb     slave modport: pclk, preset_n, 16-bit APB completer
//   irq_in  NUM_IRQS interrupt sources, already synchronous to apb.pclk
//   irq     registered interrupt request, active high
// Register map (byte address, paddr[0] ignored)
//   0x0 STATUS RW1C  0x2 ENABLE RW  0x4 MODE RW (1=edge)  0x6 POLARITY RW (1=low)
//   0x8 PENDING RO   0xA FORCE WO   0xC HOLDOFF RW        >=0xE -> pslverr
// ----------------------------------------------------------------------------
module apb_interrupt_controller #(
    parameter int          NUM_IRQS     = 16,
    parameter logic [15:0] ENABLE_INIT  = 16'h0000,
    parameter logic [15:0] MODE_INIT    = 16'h0000,
    parameter int          HOLDOFF_BITS = 16
) (
    apb_interrupt_controller_if.slave apb,
    input  logic [NUM_IRQS-1:0]       irq_in,
    output logic                      irq
);

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_ENABLE   = 3'd1,
        REG_MODE     = 3'd2,
        REG_POLARITY = 3'd3,
        REG_PENDING  = 3'd4,
        REG_FORCE    = 3'd5,
        REG_HOLDOFF  = 3'd6,
        REG_INVALID  = 3'd7
    } reg_idx_e;

    // Architectural state
    logic [NUM_IRQS-1:0]     status_q,   status_d;
    logic [NUM_IRQS-1:0]     enable_q,   enable_d;
    logic [NUM_IRQS-1:0]     mode_q,     mode_d;
    logic [NUM_IRQS-1:0]     polarity_q, polarity_d;
    logic [HOLDOFF_BITS-1:0] holdoff_q,  holdoff_d;
    logic [HOLDOFF_BITS-1:0] cnt_q,      cnt_d;
    logic [NUM_IRQS-1:0]     prev_q;
    logic                    irq_q,      irq_d;

    // APB response registers
    logic                    pready_q,   pready_d;
    logic [15:0]             prdata_q,   prdata_d;
    logic                    pslverr_q,  pslverr_d;

    // Decode and datapath
    reg_idx_e                reg_idx;
    logic [31:0]             paddr_ext;
    logic                    slv_err;
    logic                    access;
    logic                    commit;
    logic [15:0]             rdata;
    logic [NUM_IRQS-1:0]     wdata_n;
    logic [NUM_IRQS-1:0]     act;
    logic [NUM_IRQS-1:0]     set;
    logic [NUM_IRQS-1:0]     clr;
    logic [NUM_IRQS-1:0]     frc;

    // Write-data bits above NUM_IRQS / HOLDOFF_BITS are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^apb.pwdata;

    assign paddr_ext = 32'(apb.paddr);
    assign reg_idx   = reg_idx_e'(apb.paddr[3:1]);
    assign wdata_n   = apb.pwdata[NUM_IRQS-1:0];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statements can leave a value held (no latches).
        rdata      = '0;
        clr        = '0;
        frc        = '0;
        enable_d   = enable_q;
        mode_d     = mode_q;
        polarity_d = polarity_q;
        holdoff_d  = holdoff_q;

        // Anything at or above 0xE (including wider address bits) is unmapped;
        // PENDING is read-only, so writing it is an error too.
        slv_err = (paddr_ext >= 32'hE) ||
                  (apb.pwrite && (reg_idx == REG_PENDING));

        // Access phase before the one-cycle pready strobe is raised.
        access = apb.psel & apb.penable & ~pready_q;
        // Writes land on the edge that closes the pready cycle.
        commit = apb.psel & apb.penable & pready_q & apb.pwrite & ~slv_err;

        unique case (reg_idx)
            REG_STATUS:   rdata = 16'(status_q);
            REG_ENABLE:   rdata = 16'(enable_q);
            REG_MODE:     rdata = 16'(mode_q);
            REG_POLARITY: rdata = 16'(polarity_q);
            REG_PENDING:  rdata = 16'(status_q & enable_q);
            REG_HOLDOFF:  rdata = 16'(holdoff_q);
            default:      rdata = '0;   // FORCE and the unmapped slot read 0
        endcase

        if (commit) begin
            unique case (reg_idx)
                REG_STATUS:   clr        = wdata_n;
                REG_ENABLE:   enable_d   = wdata_n;
                REG_MODE:     mode_d     = wdata_n;
                REG_POLARITY: polarity_d = wdata_n;
                REG_FORCE:    frc        = wdata_n;
                REG_HOLDOFF:  holdoff_d  = apb.pwdata[HOLDOFF_BITS-1:0];
                default:      ;
            endcase
        end

        // Edge sources fire only on a 0->1 of the polarity-corrected input,
        // level sources fire whenever active.
        act = irq_in ^ polarity_q;
        set = act & (~mode_q | ~prev_q);

        // Set and force win over a simultaneous write-1-to-clear.
        status_d = (status_q & ~clr) | set | frc;

        // Only a clear that actually drops a latched bit restarts the holdoff.
        if (|(clr & status_q)) begin
            cnt_d = holdoff_q;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLDOFF_BITS'(1);
        end else begin
            cnt_d = cnt_q;
        end

        irq_d = |(status_q & enable_q) & (cnt_q == '0);

        pready_d  = access;
        pslverr_d = access & slv_err;
        prdata_d  = (access && !apb.pwrite && !slv_err) ? rdata : 16'h0000;
    end

    always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
        if (!apb.preset_n) begin
            status_q   <= '0;
            enable_q   <= ENABLE_INIT[NUM_IRQS-1:0];
            mode_q     <= MODE_INIT[NUM_IRQS-1:0];
            polarity_q <= '0;
            holdoff_q  <= '0;
            cnt_q      <= '0;
            prev_q     <= '0;
            irq_q      <= 1'b0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            status_q   <= status_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            polarity_q <= polarity_d;
            holdoff_q  <= holdoff_d;
            cnt_q      <= cnt_d;
            prev_q     <= act;
            irq_q      <= irq_d;
            pready_q   <= pready_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
        end
    end

    assign apb.pready  = pready_q;
    assign apb.prdata  = prdata_q;
    assign apb.pslverr = pslverr_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_apb_interrupt_controller.sv
// ----------------------------------------------------------------------------
// tb_apb_interrupt_controller
//   Self-checking bench: a register-access vector table plus hand-written
//   sequences for reset, edge, level, collision, holdoff and polarity cases.
//   APB responses are checked through a scoreboard queue.
// ----------------------------------------------------------------------------
module tb_apb_interrupt_controller;

    localparam int NUM_IRQS = 4;

    logic                clk;
    logic                rst_n;
    logic [NUM_IRQS-1:0] irq_in;
    logic                irq;

    apb_interrupt_controller_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus (
        .pclk     (clk),
        .preset_n (rst_n)
    );

    apb_interrupt_controller #(
        .NUM_IRQS     (NUM_IRQS),
        .ENABLE_INIT  (16'h0005),
        .MODE_INIT    (16'h0002),
        .HOLDOFF_BITS (8)
    ) dut (
        .apb    (bus.slave),
        .irq_in (irq_in),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[25];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One APB transfer. Expected response is pushed on issue and popped when
    // pready appears. 'collide' is ORed into irq_in during the pready cycle so
    // a source edge coincides with the write commit edge.
    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp_data, input logic exp_err,
                            input string name, input logic [NUM_IRQS-1:0] collide);
        exp_t e;
        bit   got;
        sb_q.push_back('{exp_data, exp_err});
        @(posedge clk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.pready) begin
                got = 1;
                break;
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            check({name, " pready timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " pslverr"}, 32'(bus.pslverr), 32'(e.err));
            if (!wr) check({name, " prdata"}, 32'(bus.prdata), 32'(e.data));
            irq_in = irq_in | collide;
        end
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        check({name, " pready one cycle"}, 32'(bus.pready), 32'd0);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] d, input string name);
        apb_xfer(1'b1, addr, d, 16'h0, 1'b0, name, '0);
    endtask

    task automatic rd(input logic [3:0] addr, input logic [15:0] exp_d, input string name);
        apb_xfer(1'b0, addr, 16'h0, exp_d, 1'b0, name, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;

        // Register-access table, starting from reset state.
        vt[0]  = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0};
        vt[1]  = '{1'b0, 4'h2, 16'h0000, 16'h0005, 1'b0};
        vt[2]  = '{1'b0, 4'h4, 16'h0000, 16'h0002, 1'b0};
        vt[3]  = '{1'b0, 4'h6, 16'h0000, 16'h0000, 1'b0};
        vt[4]  = '{1'b0, 4'h8, 16'h0000, 16'h0000, 1'b0};
        vt[5]  = '{1'b0, 4'hA, 16'h0000, 16'h0000, 1'b0};
        vt[6]  = '{1'b0, 4'hC, 16'h0000, 16'h0000, 1'b0};
        vt[7]  = '{1'b0, 4'hE, 16'h0000, 16'h0000, 1'b1};
        vt[8]  = '{1'b1, 4'h2, 16'hFFFF, 16'h0000, 1'b0};
        vt[9]  = '{1'b0, 4'h3, 16'h0000, 16'h000F, 1'b0};
        vt[10] = '{1'b1, 4'hC, 16'hFFFF, 16'h0000, 1'b0};
        vt[11] = '{1'b0, 4'hC, 16'h0000, 16'h00FF, 1'b0};
        vt[12] = '{1'b1, 4'hC, 16'h0000, 16'h0000, 1'b0};
        vt[13] = '{1'b1, 4'hA, 16'h8000, 16'h0000, 1'b0};
        vt[14] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0};
        vt[15] = '{1'b1, 4'hA, 16'h0002, 16'h0000, 1'b0};
        vt[16] = '{1'b0, 4'h0, 16'h0000, 16'h0002, 1'b0};
        vt[17] = '{1'b0, 4'h8, 16'h0000, 16'h0002, 1'b0};
        vt[18] = '{1'b1, 4'h8, 16'h000F, 16'h0000, 1'b1};
        vt[19] = '{1'b0, 4'h0, 16'h0000, 16'h0002, 1'b0};
        vt[20] = '{1'b1, 4'hE, 16'h1234, 16'h0000, 1'b1};
        vt[21] = '{1'b1, 4'h0, 16'h0002, 16'h0000, 1'b0};
        vt[22] = '{1'b0, 4'h0, 16'h0000, 16'h0000, 1'b0};
        vt[23] = '{1'b0, 4'hA, 16'h0000, 16'h0000, 1'b0};
        vt[24] = '{1'b0, 4'hF, 16'h0000, 16'h0000, 1'b1};

        rst_n       = 1'b0;
        irq_in      = '0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;

        // ---- Reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("reset irq", 32'(irq), 32'd0);
        check("reset pready", 32'(bus.pready), 32'd0);
        check("reset prdata", 32'(bus.prdata), 32'd0);
        rst_n = 1'b1;

        // ---- Reset in the middle of an ENABLE write ----
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = 4'h2; bus.pwdata = 16'h000F;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset pready", 32'(bus.pready), 32'd0);
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset irq", 32'(irq), 32'd0);
        check("midreset pslverr", 32'(bus.pslverr), 32'd0);

        // ---- Register-access table ----
        for (int i = 0; i < 25; i++) begin
            apb_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].err,
                     $sformatf("vec%0d", i), '0);
        end

        // ---- Edge mode on source 0 ----
        wr(4'h4, 16'h0001, "edge mode");
        wr(4'h2, 16'h0001, "edge enable");
        wr(4'h0, 16'h000F, "edge preclear");
        @(posedge clk); #1;
        irq_in[0] = 1'b1;
        @(posedge clk); #1;
        check("edge irq still low at latch", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("edge irq one cycle after latch", 32'(irq), 32'd1);
        @(posedge clk); #1;
        irq_in[0] = 1'b0;
        rd(4'h0, 16'h0001, "edge status");
        wr(4'h0, 16'h0001, "edge w1c");
        check("edge irq at clear edge", 32'(irq), 32'd1);
        @(posedge clk); #1;
        check("edge irq after clear", 32'(irq), 32'd0);
        rd(4'h0, 16'h0000, "edge status cleared");

        // ---- Level mode on source 2 ----
        wr(4'h4, 16'h0000, "level mode");
        wr(4'h2, 16'h0004, "level enable");
        irq_in[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("level irq set", 32'(irq), 32'd1);
        wr(4'h0, 16'h0004, "level w1c active");
        @(posedge clk); #1;
        check("level irq stays", 32'(irq), 32'd1);
        rd(4'h0, 16'h0004, "level relatched");
        irq_in[2] = 1'b0;
        wr(4'h0, 16'h0004, "level w1c idle");
        @(posedge clk); #1;
        check("level irq dropped", 32'(irq), 32'd0);
        rd(4'h0, 16'h0000, "level status cleared");

        // ---- Collision: edge on source 1 at the W1C commit edge ----
        wr(4'h4, 16'h0002, "coll mode");
        wr(4'h2, 16'h0002, "coll enable");
        wr(4'hA, 16'h0002, "coll force");
        apb_xfer(1'b1, 4'h0, 16'h0002, 16'h0, 1'b0, "coll w1c", 4'b0010);
        rd(4'h0, 16'h0002, "coll status kept");
        irq_in[1] = 1'b0;
        wr(4'h0, 16'h0002, "coll clear");
        rd(4'h0, 16'h0000, "coll status cleared");

        // ---- Holdoff of 10 cycles ----
        wr(4'hC, 16'h000A, "hold value");
        wr(4'h4, 16'h0000, "hold mode");
        wr(4'h2, 16'h0001, "hold enable");
        irq_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("hold irq before clear", 32'(irq), 32'd1);
        wr(4'h0, 16'h0001, "hold w1c");
        check("hold irq at clear edge", 32'(irq), 32'd1);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (irq == 1'b0) low_cnt++;
            else if (low_cnt > 0) break;
        end
        check("hold low cycles", 32'(low_cnt), 32'd10);
        check("hold irq reasserted", 32'(irq), 32'd1);
        irq_in[0] = 1'b0;
        wr(4'hC, 16'h0000, "hold zero");
        wr(4'h0, 16'h0001, "hold clear");
        rd(4'h0, 16'h0000, "hold status cleared");

        // ---- Active-low source 3 and enable gating ----
        wr(4'h6, 16'h0008, "pol write");
        repeat (2) @(posedge clk);
        rd(4'h0, 16'h0008, "pol status");
        rd(4'h8, 16'h0000, "pol pending gated");
        wr(4'h2, 16'h0008, "pol enable");
        repeat (15) @(posedge clk);
        #1;
        check("pol irq", 32'(irq), 32'd1);
        rd(4'h8, 16'h0008, "pol pending");

        check("scoreboard empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
